// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: default widths
// and the arbitration state encoding.
package mem_arbiter_pkg;

    localparam int DW = 8;
    localparam int AW = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    // Lock state that belongs to a given requester index.
    function automatic arb_state_t lock_state(input logic idx);
        return idx ? LOCK1 : LOCK0;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Single-port memory bus between the arbiter (master) and the external
// memory (slave). Read data returns one cycle after mem_rd.
interface mem_arbiter_if #(
    parameter int DW = mem_arbiter_pkg::DW,
    parameter int AW = mem_arbiter_pkg::AW
);

    logic [DW-1:0] mem_din;
    logic [AW-1:0] mem_waddr;
    logic [AW-1:0] mem_raddr;
    logic          mem_wr;
    logic          mem_rd;
    logic [DW-1:0] mem_dout;

    modport master (
        output mem_din,
        output mem_waddr,
        output mem_raddr,
        output mem_wr,
        output mem_rd,
        input  mem_dout
    );

    modport slave (
        input  mem_din,
        input  mem_waddr,
        input  mem_raddr,
        input  mem_wr,
        input  mem_rd,
        output mem_dout
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick with lock support: grant is combinational from
// req, arbitration state and priority pointer; state and pointer are registered.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic lock0,
    input  logic lock1,
    output logic gnt0,
    output logic gnt1
);

    arb_state_t state_reg;
    logic       ptr_reg;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    if (req0 && req1) begin
                        gnt0 = ~ptr_reg;
                        gnt1 = ptr_reg;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
                // The non-owner is ignored entirely while a lock is held.
                LOCK0:   gnt0 = req0;
                LOCK1:   gnt1 = req1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (gnt0) begin
                        if (lock0) state_reg <= lock_state(1'b0);
                        else       ptr_reg   <= 1'b1;
                    end else if (gnt1) begin
                        if (lock1) state_reg <= lock_state(1'b1);
                        else       ptr_reg   <= 1'b0;
                    end
                end
                // Leaving a lock hands priority to the requester that was shut out.
                LOCK0: begin
                    if (!req0 || !lock0) begin
                        state_reg <= IDLE;
                        ptr_reg   <= 1'b1;
                    end
                end
                LOCK1: begin
                    if (!req1 || !lock1) begin
                        state_reg <= IDLE;
                        ptr_reg   <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory: one access per
// cycle, round-robin with read-modify-write locking, registered read return.
module mem_arbiter #(
    parameter int DW = mem_arbiter_pkg::DW,
    parameter int AW = mem_arbiter_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    mem_arbiter_if.master mem_bus
);

    logic          gnt_v    [2];
    logic          we_v     [2];
    logic [AW-1:0] addr_v   [2];
    logic [DW-1:0] wdata_v  [2];
    logic          rvalid_v [2];
    logic [DW-1:0] rdata_v  [2];
    logic          sel;
    logic          any_gnt;

    assign we_v[0]    = we0;
    assign we_v[1]    = we1;
    assign addr_v[0]  = addr0;
    assign addr_v[1]  = addr1;
    assign wdata_v[0] = wdata0;
    assign wdata_v[1] = wdata1;

    rr_pick2 u_pick (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .req1  (req1),
        .lock0 (lock0),
        .lock1 (lock1),
        .gnt0  (gnt_v[0]),
        .gnt1  (gnt_v[1])
    );

    assign gnt0 = gnt_v[0];
    assign gnt1 = gnt_v[1];

    // Grants are one-hot, so gnt1 alone selects the owner of the memory port.
    assign sel     = gnt_v[1];
    assign any_gnt = gnt_v[0] | gnt_v[1];

    always_comb begin
        mem_bus.mem_wr    = any_gnt & we_v[sel];
        mem_bus.mem_rd    = any_gnt & ~we_v[sel];
        mem_bus.mem_waddr = addr_v[sel];
        mem_bus.mem_raddr = addr_v[sel];
        mem_bus.mem_din   = wdata_v[sel];
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ret
            logic          rvalid_reg;
            logic [DW-1:0] hold_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rvalid_reg <= 1'b0;
                    hold_reg   <= '0;
                end else begin
                    rvalid_reg <= gnt_v[gi] & ~we_v[gi];
                    if (rvalid_reg) hold_reg <= mem_bus.mem_dout;
                end
            end

            // Memory data is already registered, so it is passed straight out in
            // the valid cycle and held afterwards. Reset masks a return still in
            // flight so a read granted just before reset never shows valid.
            assign rvalid_v[gi] = rvalid_reg & ~rst;
            assign rdata_v[gi]  = rst ? '0 : (rvalid_reg ? mem_bus.mem_dout : hold_reg);
        end
    endgenerate

    assign rvalid0 = rvalid_v[0];
    assign rvalid1 = rvalid_v[1];
    assign rdata0  = rdata_v[0];
    assign rdata1  = rdata_v[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory, arbitration model
// and per-requester read-data scoreboards, directed scenarios then random traffic.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;

    always #5 clk = ~clk;

    mem_arbiter_if #(.DW(DW), .AW(AW)) mif ();

    mem_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .we0     (we0),
        .we1     (we1),
        .lock0   (lock0),
        .lock1   (lock1),
        .addr0   (addr0),
        .addr1   (addr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1),
        .rdata0  (rdata0),
        .rdata1  (rdata1),
        .mem_bus (mif)
    );

    // External memory: write lands on the edge, read data one cycle after mem_rd.
    logic [DW-1:0] mem_model [1<<AW];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < (1<<AW); i++) mem_model[i] <= '0;
        end else begin
            if (mif.mem_wr) mem_model[mif.mem_waddr] <= mif.mem_din;
            if (mif.mem_rd) mif.mem_dout <= mem_model[mif.mem_raddr];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int            m_state = 0;
    logic          m_ptr = 1'b0;
    logic          exp_rv0 = 1'b0, exp_rv1 = 1'b0;
    logic [DW-1:0] last_rd0 = '0, last_rd1 = '0;
    logic [DW-1:0] ref_mem [1<<AW];
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    int            w0 = 0, w1 = 0;

    // Observations from the most recent step, for directed checks.
    logic          obs_g0, obs_g1, obs_wr, obs_rd, obs_rv0, obs_rv1;
    logic [DW-1:0] obs_rdata0, obs_rdata1;

    task automatic set_req(input int r, input logic rq, input logic w, input logic lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (r == 0) begin
            req0 = rq; we0 = w; lock0 = lk; addr0 = a; wdata0 = d;
        end else begin
            req1 = rq; we1 = w; lock1 = lk; addr1 = a; wdata1 = d;
        end
    endtask

    // Called at a negedge with inputs for this cycle already driven.
    task automatic step();
        logic          e0, e1;
        logic [DW-1:0] exp_d;
        #1;
        obs_g0 = gnt0; obs_g1 = gnt1; obs_wr = mif.mem_wr; obs_rd = mif.mem_rd;
        obs_rv0 = rvalid0; obs_rv1 = rvalid1; obs_rdata0 = rdata0; obs_rdata1 = rdata1;

        check("rvalid0", 32'(rvalid0), 32'(!rst && exp_rv0));
        if (!rst && exp_rv0) last_rd0 = q0.pop_front();
        exp_d = rst ? '0 : last_rd0;
        check("rdata0", 32'(rdata0), 32'(exp_d));
        check("rvalid1", 32'(rvalid1), 32'(!rst && exp_rv1));
        if (!rst && exp_rv1) last_rd1 = q1.pop_front();
        exp_d = rst ? '0 : last_rd1;
        check("rdata1", 32'(rdata1), 32'(exp_d));

        e0 = 1'b0; e1 = 1'b0;
        if (!rst) begin
            case (m_state)
                0: if (req0 && req1) begin e0 = !m_ptr; e1 = m_ptr; end
                   else begin e0 = req0; e1 = req1; end
                1: e0 = req0;
                2: e1 = req1;
                default: ;
            endcase
        end
        check("gnt0", 32'(gnt0), 32'(e0));
        check("gnt1", 32'(gnt1), 32'(e1));
        check("gnt_both", 32'(gnt0 & gnt1), 32'd0);
        check("mem_wr", 32'(mif.mem_wr), 32'((e0 && we0) || (e1 && we1)));
        check("mem_rd", 32'(mif.mem_rd), 32'((e0 && !we0) || (e1 && !we1)));
        if (e0 && we0) begin
            check("waddr0", 32'(mif.mem_waddr), 32'(addr0));
            check("wdin0", 32'(mif.mem_din), 32'(wdata0));
        end
        if (e1 && we1) begin
            check("waddr1", 32'(mif.mem_waddr), 32'(addr1));
            check("wdin1", 32'(mif.mem_din), 32'(wdata1));
        end
        if (e0 && !we0) check("raddr0", 32'(mif.mem_raddr), 32'(addr0));
        if (e1 && !we1) check("raddr1", 32'(mif.mem_raddr), 32'(addr1));

        // Starvation: waiting is only counted in unlocked cycles.
        if (!req0) w0 = 0;
        if (!req1) w1 = 0;
        if (!rst && m_state == 0) begin
            if (req0 && !e0) w0++;
            if (req1 && !e1) w1++;
        end
        if (e0) begin check("starve0", 32'(w0 <= 1), 32'd1); w0 = 0; end
        if (e1) begin check("starve1", 32'(w1 <= 1), 32'd1); w1 = 0; end

        if (e0) $display("txn t=%0t req0 %s addr=%0d data=%02h%s", $time, we0 ? "WR" : "RD",
                         addr0, we0 ? wdata0 : ref_mem[addr0], lock0 ? " lock" : "");
        if (e1) $display("txn t=%0t req1 %s addr=%0d data=%02h%s", $time, we1 ? "WR" : "RD",
                         addr1, we1 ? wdata1 : ref_mem[addr1], lock1 ? " lock" : "");

        if (rst) begin
            m_state = 0; m_ptr = 1'b0;
            exp_rv0 = 1'b0; exp_rv1 = 1'b0;
            last_rd0 = '0; last_rd1 = '0;
            q0.delete(); q1.delete();
            w0 = 0; w1 = 0;
            for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
        end else begin
            exp_rv0 = e0 && !we0;
            exp_rv1 = e1 && !we1;
            if (e0) begin
                if (we0) ref_mem[addr0] = wdata0;
                else     q0.push_back(ref_mem[addr0]);
            end
            if (e1) begin
                if (we1) ref_mem[addr1] = wdata1;
                else     q1.push_back(ref_mem[addr1]);
            end
            case (m_state)
                0: if (e0) begin if (lock0) m_state = 1; else m_ptr = 1'b1; end
                   else if (e1) begin if (lock1) m_state = 2; else m_ptr = 1'b0; end
                1: if (!req0 || !lock0) begin m_state = 0; m_ptr = 1'b1; end
                2: if (!req1 || !lock1) begin m_state = 0; m_ptr = 1'b0; end
                default: ;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);

        // Reset with both requesters held, then first cycle after release
        set_req(0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        set_req(1, 1'b1, 1'b0, 1'b0, 2'd1, 8'h00);
        step();
        check("r21_gnt_in_rst", 32'({obs_g1, obs_g0}), 32'd0);
        check("r21_rv_in_rst", 32'({obs_rv1, obs_rv0}), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("r21_gnt0_release", 32'(obs_g0), 32'd1);

        // Write then read of the same address on the next cycle
        set_req(0, 1'b1, 1'b1, 1'b0, 2'd2, 8'h5A);
        set_req(1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        step();
        check("r22_mem_wr", 32'(obs_wr), 32'd1);
        set_req(0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        set_req(1, 1'b1, 1'b0, 1'b0, 2'd2, 8'h00);
        step();
        check("r22_gnt1", 32'(obs_g1), 32'd1);
        check("r22_mem_rd", 32'(obs_rd), 32'd1);
        set_req(1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        step();
        check("r22_rvalid1", 32'(obs_rv1), 32'd1);
        check("r22_rdata1", 32'(obs_rdata1), 32'h5A);

        // Both reading continuously: strict alternation starting with 0
        set_req(0, 1'b1, 1'b0, 1'b0, 2'd1, 8'h00);
        set_req(1, 1'b1, 1'b0, 1'b0, 2'd3, 8'h00);
        for (int i = 0; i < 6; i++) begin
            step();
            check("r23_gnt0", 32'(obs_g0), 32'(i % 2 == 0));
            check("r23_gnt1", 32'(obs_g1), 32'(i % 2 == 1));
            if (i > 0) check("r23_rv0", 32'(obs_rv0), 32'(i % 2 == 1));
        end
        set_req(0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        set_req(1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        step();
        check("r23_rv1_last", 32'(obs_rv1), 32'd1);

        // Locked read-modify-write by requester 0 while requester 1 waits
        set_req(0, 1'b1, 1'b0, 1'b1, 2'd2, 8'h00);
        set_req(1, 1'b1, 1'b0, 1'b0, 2'd2, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            check("r24_gnt0_lock", 32'(obs_g0), 32'd1);
            check("r24_gnt1_lock", 32'(obs_g1), 32'd0);
        end
        set_req(0, 1'b1, 1'b1, 1'b0, 2'd2, 8'hC3);
        step();
        check("r24_gnt0_commit", 32'(obs_g0), 32'd1);
        check("r24_gnt1_commit", 32'(obs_g1), 32'd0);
        set_req(0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        step();
        check("r24_gnt1_after", 32'(obs_g1), 32'd1);
        set_req(1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        step();
        check("r24_rdata1", 32'(obs_rdata1), 32'hC3);

        // Reset in the cycle after a read grant
        set_req(0, 1'b1, 1'b0, 1'b0, 2'd3, 8'h00);
        step();
        check("r25_gnt0", 32'(obs_g0), 32'd1);
        set_req(0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        rst = 1'b1;
        step();
        check("r25_rv0_rst", 32'(obs_rv0), 32'd0);
        check("r25_rdata_rst", 32'({obs_rdata1, obs_rdata0}), 32'd0);
        check("r25_strobe_rst", 32'({obs_wr, obs_rd}), 32'd0);
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        set_req(1, 1'b1, 1'b0, 1'b0, 2'd1, 8'h00);
        step();
        check("r25_ptr0", 32'(obs_g0), 32'd1);
        check("r25_rv_after", 32'({obs_rv1, obs_rv0}), 32'd0);

        // Random traffic; requesters hold their fields until granted
        for (int c = 0; c < 1000; c++) begin
            if (!req0 || obs_g0)
                set_req(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 3) == 0), AW'($urandom), DW'($urandom));
            if (!req1 || obs_g1)
                set_req(1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 3) == 0), AW'($urandom), DW'($urandom));
            step();
        end
        set_req(0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        set_req(1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: DW, default 8, data width; AW, default 2, address width (4-entry memory).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req0, req1  in  1  access request, one per requester.
- we0, we1  in  1  1 = write, 0 = read.
- lock0, lock1  in  1  keep ownership for the next cycle (read-modify-write).
- addr0, addr1  in  AW  word address.
- wdata0, wdata1  in  DW  write data.
- gnt0, gnt1  out  1  request accepted this cycle.
- rvalid0, rvalid1  out  1  read data valid.
- rdata0, rdata1  out  DW  read data.
- mem_din  out  DW  memory write data.
- mem_waddr  out  AW  memory write address.
- mem_raddr  out  AW  memory read address.
- mem_wr  out  1  memory write strobe.
- mem_rd  out  1  memory read strobe.
- mem_dout  in  DW  memory read data, valid one cycle after mem_rd.

Function
REQ-004 At most one of gnt0/gnt1 SHALL be high in any cycle; gnt SHALL be combinational from req, state and priority pointer.
REQ-005 A requester SHALL hold req, we, addr and wdata stable until it sees gnt; the transfer completes on the clk edge where gnt is high.
REQ-006 In the grant cycle, the granted requester's fields SHALL drive the memory port:
- write: mem_wr=1, mem_waddr=addr, mem_din=wdata.
- read: mem_rd=1, mem_raddr=addr.
- no grant: mem_wr=0 and mem_rd=0.
REQ-007 A read granted in cycle N SHALL produce rvalidX=1 for exactly one cycle in N+1, with rdataX=mem_dout; rvalid/rdata SHALL be registered.
REQ-008 rdataX SHALL hold its last value while rvalidX=0.
REQ-009 Arbitration states SHALL be IDLE, LOCK0, LOCK1.
REQ-010 In IDLE:
- single requester: granted immediately.
- both requesting: the requester named by a 1-bit priority pointer wins.
- after any grant, the pointer SHALL point to the other requester.
REQ-011 A grant with lockX=1 SHALL move the state to LOCKX; the pointer SHALL not update while locked.
REQ-012 In LOCKX:
- only requester X may be granted; the other requester's req SHALL be ignored.
- exit to IDLE after a grant to X with lockX=0, or in any cycle where reqX=0.
- on exit, the pointer SHALL point to the other requester.
REQ-013 Back-to-back grants SHALL be supported with no idle cycle: 1 access per cycle throughput.
REQ-014 A write followed next cycle by a read of the same address SHALL return the new data; this relies on the memory's write-before-read-next-cycle behaviour, and the arbiter SHALL add no forwarding.
REQ-015 Simultaneous requests to the same address from both requesters SHALL be serialised by REQ-010 and REQ-012; there is no merging.

Reset
REQ-016 rst SHALL force, on the next clk edge:
- state=IDLE, pointer=0 (requester 0 priority).
- rvalid0=rvalid1=0, rdata0=rdata1=0.
REQ-017 While rst=1, gnt0, gnt1, mem_wr and mem_rd SHALL be 0.
REQ-018 A read granted in the cycle before rst asserts SHALL NOT produce rvalid.

Structure
REQ-019 DW, AW and the state encoding (IDLE=0, LOCK0=1, LOCK1=2) SHALL live in the shared processor package.
REQ-020 The 2-way round-robin pick (pointer plus grant logic) SHALL be a sub-module named rr_pick2; the memory itself remains external.

Verification
REQ-021 Reset with req0=req1=1 held -> gnt0=gnt1=0 and rvalid=0 during rst; in the first cycle after release, gnt0=1.
REQ-022 req0 write addr=2 wdata=0x5A, then req1 read addr=2 next cycle -> mem_wr then mem_rd; rvalid1=1 with rdata1=0x5A one cycle after gnt1.
REQ-023 req0 and req1 both held as reads for 6 cycles -> grants alternate 0,1,0,1,0,1; each rvalid arrives one cycle after its grant.
REQ-024 req0 with lock0=1 for 3 cycles while req1 is held -> gnt0 for 3 cycles, gnt1=0; gnt1 in the cycle after lock0 drops.
REQ-025 rst asserted in the cycle after a read grant -> no rvalid pulse, all outputs at reset values, pointer=0.
REQ-026 Continuous random traffic for 1000 cycles, checked against a scoreboard -> gnt never high on both requesters, no request starved beyond 1 cycle outside lock, all read data correct.
